// File: rtl/fpu_adder_arbiter_pkg.sv
// ============================================================================
// fpu_arb_pkg : shared constants for the round-robin FP adder arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_arb_pkg;

  localparam int FLOAT_W = 32;
  localparam int ST_W    = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_SEND_A = 3'd1;
  localparam logic [ST_W-1:0] ST_SEND_B = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_Z = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_adder_arbiter_if.sv
// ============================================================================
// fpu_adder_arbiter_if : stb/ack handshake bundle to the shared FP adder
// Rev 1.0
// ============================================================================
`default_nettype none

interface fpu_adder_arbiter_if;
  import fpu_arb_pkg::*;

  logic [FLOAT_W-1:0] add_a;
  logic [FLOAT_W-1:0] add_b;
  logic               add_a_stb;
  logic               add_b_stb;
  logic               add_z_ack;
  logic [FLOAT_W-1:0] add_z;
  logic               add_z_stb;
  logic               add_a_ack;
  logic               add_b_ack;

  modport master (
    output add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    input  add_z, add_z_stb, add_a_ack, add_b_ack
  );

  modport slave (
    input  add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    output add_z, add_z_stb, add_a_ack, add_b_ack
  );

endinterface

`default_nettype wire

// File: rtl/fpu_adder_arbiter_rr_pick.sv
// ============================================================================
// fpu_rr_pick : combinational rotating-priority picker, search starts at pointer+1
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               any,
  output logic [IDX_W-1:0]   winner
);

  int w_dist;
  int w_best;

  // Distance 0 is the slot just after the pointer; the pointer itself is farthest.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        w_dist = (i + NUM_REQ - 1 - int'(pointer)) % NUM_REQ;
        if (w_dist < w_best) begin
          w_best = w_dist;
          winner = IDX_W'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_adder_arbiter.sv
// ============================================================================
// fpu_adder_arbiter : round-robin sharing of one stb/ack FP adder among NUM_REQ
// requesters; snapshots operands, sequences A/B/Z handshakes, pulses done.
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [FLOAT_W*NUM_REQ-1:0] op_a,
  input  logic [FLOAT_W*NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0]         done,
  output logic [FLOAT_W-1:0]         result,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_id,
  fpu_adder_arbiter_if.master        add
);

  localparam int C_IDX_W_EXP = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1;

  generate
    if (IDX_W != C_IDX_W_EXP) begin : g_idx_check
      $error("fpu_adder_arbiter: IDX_W must equal max(1, clog2(NUM_REQ))");
    end
  endgenerate

  logic [ST_W-1:0]    r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [FLOAT_W-1:0] r_result;
  logic               r_busy;
  logic [FLOAT_W-1:0] r_add_a;
  logic [FLOAT_W-1:0] r_add_b;
  logic               r_a_stb;
  logic               r_b_stb;
  logic               r_z_ack;

  logic               w_any;
  logic [IDX_W-1:0]   w_winner;
  logic [FLOAT_W-1:0] w_op_a [NUM_REQ];
  logic [FLOAT_W-1:0] w_op_b [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_op_a[g] = op_a[g*FLOAT_W +: FLOAT_W];
      assign w_op_b[g] = op_b[g*FLOAT_W +: FLOAT_W];
    end
  endgenerate

  fpu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .pointer (r_ptr),
    .any     (w_any),
    .winner  (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= IDX_W'(NUM_REQ - 1);
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_a_stb  <= 1'b0;
      r_b_stb  <= 1'b0;
      r_z_ack  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_ptr   <= w_winner;
            r_add_a <= w_op_a[w_winner];
            r_add_b <= w_op_b[w_winner];
            r_a_stb <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (add.add_a_ack) begin
            r_a_stb <= 1'b0;
            r_b_stb <= 1'b1;
            r_state <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (add.add_b_ack) begin
            r_b_stb <= 1'b0;
            r_z_ack <= 1'b1;
            r_state <= ST_WAIT_Z;
          end
        end
        ST_WAIT_Z: begin
          if (add.add_z_stb) begin
            r_result <= add.add_z;
            r_z_ack  <= 1'b0;
            r_done   <= NUM_REQ'(1) << r_grant;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Extra cycle lets a registered requester retract req before re-arbitration.
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_a_stb <= 1'b0;
          r_b_stb <= 1'b0;
          r_z_ack <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done          = r_done;
  assign result        = r_result;
  assign busy          = r_busy;
  assign grant_id      = r_grant;
  assign add.add_a     = r_add_a;
  assign add.add_b     = r_add_b;
  assign add.add_a_stb = r_a_stb;
  assign add.add_b_stb = r_b_stb;
  assign add.add_z_ack = r_z_ack;

endmodule

`default_nettype wire

// File: doc/fpu_adder_arbiter.md
Name: fpu_adder_arbiter

Overview:
- Round-robin scheduler that shares one stb/ack floating-point adder (single precision, 32-bit operands) between NUM_REQ requesters.
- Snapshots the granted requester's operands and drives the adder's A, B and Z handshakes in order.
- Returns the sum with a one-cycle done pulse to the owning requester.
- Sits between the Avalon-facing register slaves / compute masters and the shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
IDX_W, 2, width of grant index; must equal max(1, clog2(NUM_REQ))

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester level request; operands valid while high
op_a  input  32*NUM_REQ  flattened operand A; requester i at [32*i+31:32*i]
op_b  input  32*NUM_REQ  flattened operand B, same packing
done  output  NUM_REQ  one-hot, one-cycle pulse marking the result owner
result  output  32  sum; valid while done is nonzero, held until the next done
busy  output  1  high whenever state is not IDLE
grant_id  output  IDX_W  index of the current/last served requester
add_a  output  32  operand A to adder
add_b  output  32  operand B to adder
add_a_stb  output  1  A strobe to adder
add_b_stb  output  1  B strobe to adder
add_z_ack  output  1  result acknowledge to adder
add_z  input  32  adder result
add_z_stb  input  1  adder result strobe
add_a_ack  input  1  adder accepted A
add_b_ack  input  1  adder accepted B

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation: the transaction is aborted immediately without a clock edge, and no done is produced. The adder shares this reset.
- All outputs are registered.
- FSM: IDLE -> SEND_A -> SEND_B -> WAIT_Z -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 upward with wrap-around modulo NUM_REQ.
  - Register grant_id; pointer <= winner.
  - Copy op_a/op_b slices into add_a/add_b; add_a_stb <= 1; go to SEND_A.
  - With no requests, stay in IDLE.
- SEND_A: hold add_a_stb until add_a_ack=1 at a clock edge; then add_a_stb <= 0, add_b_stb <= 1; go to SEND_B.
- SEND_B: on add_b_ack=1, add_b_stb <= 0, add_z_ack <= 1; go to WAIT_Z.
- WAIT_Z: on add_z_stb=1, result <= add_z, add_z_ack <= 0, done[grant_id] <= 1; go to DONE.
- DONE:
  - done is high for exactly this cycle; next edge clears it and returns to IDLE.
  - This cycle lets a registered requester drop req before the next arbitration.
- Operand snapshot: add_a/add_b stay constant from grant until return to IDLE. Requester operand or req changes after grant have no effect.
- Requester drops req after grant: the operation completes and done still pulses.
- Repeat grants: a requester still requesting in IDLE after its done starts a new operation. It has lowest priority, so it is re-granted only if no other requester is pending.
- Handshake acks arriving in non-matching states (e.g. add_z_stb in SEND_A) are ignored.
- Latency: minimum 4 cycles from IDLE-with-req to done (1 cycle per state) plus adder stall cycles.
- No timeout; adder stalls hold the FSM indefinitely.
- NUM_REQ=1: pointer logic degenerates to always granting 0.

Decomposition:
- Package fpu_arb_pkg:
  - state encoding localparams (IDLE, SEND_A, SEND_B, WAIT_Z, DONE);
  - FLOAT_W=32;
  - the clog2 function used to check IDX_W.
- Sub-module fpu_rr_pick: combinational rotating-priority picker.
  - Inputs: req, pointer. Outputs: any, winner index.
- Test Plan:

Test Plan:
- Single request: req=0001, op_a[0]=0x3F800000, op_b[0]=0x40000000 -> add_a_stb with add_a=0x3F800000, then add_b_stb with 0x40000000; done=0001 for one cycle; result=0x40400000; busy low one cycle after done.
- All four req held high from reset: -> grant_id sequence 0,1,2,3,0; each done one-hot matching grant_id; no requester served twice before the others.
- req[2] and req[1] pending while requester 2 is being served (pointer=2): -> next grant is 1, then 2 again; never 2 twice in a row.
- Adder delays add_a_ack 5 cycles while op_a[0] changes to 0xDEADBEEF: -> add_a_stb held 5 cycles; add_a stays 0x3F800000; result uses the original operand.
- Assert reset asynchronously during WAIT_Z with req[0] held: -> all outputs 0 before the next clk edge; no done; after release requester 0 is re-served and receives a correct result.
- Requester 3 drops req in the cycle after grant: -> operation completes; done=1000 pulses; no further grant while req=0.
